// File: rtl/fetch_seq_ctrl.sv
// Front-end fetch sequencer: owns the PC, drives the instruction-memory request
// and produces IF/ID write/flush and ID/EX bubble controls.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FETCH    | requesting word at pc; arbitrates hazard/halt/redirect/seq
//   WAIT_MEM | memory has not returned; ID holds a NOP, optional pending redirect
//   HALT     | fetch stopped by HLT in ID; only reset leaves
module fetch_seq_ctrl #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [15:0] id_instr,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        ex_sets_flags,
  input  logic        load_use,
  output logic [15:0] pc,
  output logic        imem_req,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        halted,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    FETCH    = 2'b00,
    WAIT_MEM = 2'b01,
    HALT     = 2'b10
  } state_t;

  state_t      st;
  logic [15:0] pc_q;
  logic        pend;
  logic [15:0] pend_tgt;

  logic cond_br;
  logic flag_stall;
  logic hz;
  logic is_hlt;
  logic unused_instr_bits;

  assign cond_br    = (id_instr[15:13] == 3'b110) && (id_instr[11:9] != 3'b111);
  assign flag_stall = cond_br && ex_sets_flags;
  assign hz         = load_use || flag_stall;
  assign is_hlt     = (id_instr[15:12] == HLT_OPCODE);
  assign unused_instr_bits = ^id_instr[8:0];

  assign pc    = pc_q;
  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= FETCH;
      pc_q     <= RESET_PC;
      pend     <= 1'b0;
      pend_tgt <= 16'h0000;
    end else begin
      case (st)
        FETCH: begin
          if (hz) begin
            // hold: the same pc is refetched next cycle
          end else if (is_hlt) begin
            st <= HALT;
          end else if (branch_taken) begin
            if (imem_valid) begin
              pc_q <= branch_target;
            end else begin
              pend     <= 1'b1;
              pend_tgt <= branch_target;
              st       <= WAIT_MEM;
            end
          end else if (imem_valid) begin
            pc_q <= pc_q + 16'd2;
          end else begin
            st <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (imem_valid) begin
            if (pend) begin
              pc_q <= pend_tgt;
              pend <= 1'b0;
            end else begin
              pc_q <= pc_q + 16'd2;
            end
            st <= FETCH;
          end
        end
        HALT: begin
        end
        default: st <= FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (st)
        FETCH: begin
          imem_req = 1'b1;
          if (hz) begin
            idex_bubble = 1'b1;
          end else if (is_hlt || branch_taken || !imem_valid) begin
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
          end else begin
            ifid_we = 1'b1;
          end
        end
        WAIT_MEM: begin
          imem_req = 1'b1;
          ifid_we  = 1'b1;
          // a returning word is kept only when no redirect is pending
          ifid_flush = !(imem_valid && !pend);
        end
        HALT: begin
          idex_bubble = 1'b1;
          halted      = 1'b1;
        end
        default: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Front-end sequencer. Owns the architectural PC register and drives the instruction-memory request handshake.
- Arbitrates between PC sources each cycle: sequential (pc+2), branch redirect from ID-stage branch resolution, hazard hold, memory-wait hold and halt.
- Generates IF/ID write/flush and ID/EX bubble controls for the 16-bit pipelined CPU.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HLT_OPCODE, 4'hF, value of id_instr[15:12] that halts fetch.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- imem_valid  in  1  instruction memory has returned the word at pc this cycle
- id_instr  in  16  instruction currently in ID
- branch_taken  in  1  ID branch resolved taken (from branch-condition logic)
- branch_target  in  16  redirect target for a taken branch
- ex_sets_flags  in  1  instruction in EX writes the flag register
- load_use  in  1  load-use hazard detected on the ID instruction
- pc  out  16  current fetch address
- imem_req  out  1  fetch request; pc is stable while high
- ifid_we  out  1  IF/ID register write enable
- ifid_flush  out  1  load NOP into IF/ID; dominates ifid_we
- idex_bubble  out  1  insert NOP into ID/EX; ID instruction is held
- halted  out  1  fetch stopped by halt
- state  out  2  00 FETCH, 01 WAIT_MEM, 10 HALT

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_PC, state=FETCH, pend=0, pend_tgt=0, halted=0. While rst is high, outputs are imem_req=0, ifid_we=0, ifid_flush=1, idex_bubble=1.
- cond_br = (id_instr[15:13]==3'b110) && (id_instr[11:9]!=3'b111).
- flag_stall = cond_br && ex_sets_flags.
- hz = load_use || flag_stall.
- Outputs are combinational from state and inputs. pc, state, pend and pend_tgt are registered.
- FETCH: imem_req=1. Per-cycle priority is hz > halt > redirect > memory status.
  - hz: pc held, ifid_we=0, ifid_flush=0, idex_bubble=1. branch_taken and imem_valid are ignored; the same pc is refetched next cycle.
  - Halt (id_instr[15:12]==HLT_OPCODE): pc held, ifid_we=1, ifid_flush=1, next state=HALT.
  - branch_taken with imem_valid=1: pc<=branch_target, ifid_we=1, ifid_flush=1 (wrong-path word discarded), stay in FETCH.
  - branch_taken with imem_valid=0: pc held, pend<=1, pend_tgt<=branch_target, ifid_we=1, ifid_flush=1, next state=WAIT_MEM.
  - No branch, imem_valid=1: pc<=pc+2 (16-bit wrap, FFFE->0000), ifid_we=1, ifid_flush=0.
  - No branch, imem_valid=0: pc held, ifid_we=1, ifid_flush=1, next state=WAIT_MEM.
- WAIT_MEM: imem_req=1, pc stable. ID holds a NOP here, so branch_taken, hz and halt are ignored.
  - imem_valid=0: ifid_we=1, ifid_flush=1, stay in WAIT_MEM.
  - imem_valid=1 with pend=1: word discarded (ifid_flush=1), pc<=pend_tgt, pend<=0, next state=FETCH.
  - imem_valid=1 with pend=0: ifid_we=1, ifid_flush=0, pc<=pc+2, next state=FETCH.
- HALT: imem_req=0, ifid_we=0, ifid_flush=0, idex_bubble=1, halted=1, pc frozen at the address following the halt. Only rst exits HALT.
- idex_bubble=0 in every case not listed above.
- Reset mid-WAIT_MEM or mid-HALT: pend cleared, pc=RESET_PC, state=FETCH. Any in-flight imem_valid in the cycle after reset is treated as a response for RESET_PC.
- Latency: a taken branch redirects pc one edge after resolution with one flushed slot, or after memory return plus one edge when pending.

Test Plan:
- Reset, then imem_valid=1 constant, no hazards -> pc sequence 0000,0002,0004,0006; ifid_we=1, ifid_flush=0, state=00 throughout.
- At pc=0006: branch_taken=1, branch_target=0040, imem_valid=1 -> same cycle ifid_flush=1; next cycle pc=0040, then 0042.
- At pc=0010: imem_valid=0 with branch_taken=1, target=0080, then valid low for 3 cycles, then high -> state=01, pc=0010 held; on return ifid_flush=1, then pc=0080, state=00.
- id_instr=16'hC400 (cond branch, C=010), ex_sets_flags=1, branch_taken=1 -> idex_bubble=1, pc held, no redirect; next cycle ex_sets_flags=0 -> redirect taken.
- id_instr=16'hF000 at pc=0020 -> ifid_flush=1; next cycle state=10, halted=1, imem_req=0, pc=0020 held for 10 cycles; assert rst -> pc=0000, state=00, halted=0.
- load_use=1 for 2 cycles at pc=0030 with imem_valid=1 -> pc=0030 held, ifid_we=0, idex_bubble=1; then pc=0032. Separately, pc=FFFE with valid -> pc wraps to 0000.
